// File: rtl/mmss_game_timer_if.sv
// mmss_game_timer_if: button pulses in, display digits and status flags out
interface mmss_game_timer_if;
   logic        start_stop;
   logic        clear;
   logic        lap;
   logic [31:0] sevseg_32bit_hex_val;
   logic        running;
   logic        sec_tick;
   logic        overflow;
   modport master (
      output start_stop, clear, lap,
      input  sevseg_32bit_hex_val, running, sec_tick, overflow
   );
   modport slave (
      input  start_stop, clear, lap,
      output sevseg_32bit_hex_val, running, sec_tick, overflow
   );
endinterface

// File: rtl/mmss_game_timer.sv
// mmss_game_timer: MM:SS BCD stopwatch with lap capture, pause and 99:59 saturation
module mmss_game_timer #(
   parameter int unsigned TICKS_PER_SEC = 25_200_000
) (
   input  logic               pixel_clk,
   input  logic               rst_n,
   mmss_game_timer_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
   localparam logic [25:0] PRESC_MAX = 26'(TICKS_PER_SEC - 1);
   state_t      state, state_n;
   logic [25:0] presc;
   logic [3:0]  su, st, mu, mt, l_su, l_st, l_mu, l_mt;
   logic        tick, at_max, c_su, c_st, c_mu;
   assign tick   = (state == RUN) && (presc == PRESC_MAX);
   assign at_max = {mt, mu, st, su} == 16'h9959;
   assign c_su   = su == 4'd9;
   assign c_st   = c_su && st == 4'd5;
   assign c_mu   = c_st && mu == 4'd9;
   assign bus.sevseg_32bit_hex_val = {l_mt, l_mu, l_st, l_su, mt, mu, st, su};
   // state register
   always_ff @(posedge pixel_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   // next state: clear dominates, a saturating tick overrides start_stop
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start_stop ? RUN : IDLE;
         RUN:     state_n = (tick && at_max) ? DONE : bus.start_stop ? PAUSED : RUN;
         PAUSED:  state_n = bus.start_stop ? RUN : PAUSED;
         default: state_n = DONE;
      endcase
      if (bus.clear) state_n = IDLE;
   end
   // registered status flags, decoded from the upcoming state
   always_ff @(posedge pixel_clk or negedge rst_n)
      if (!rst_n) begin
         bus.running  <= 1'b0;
         bus.overflow <= 1'b0;
         bus.sec_tick <= 1'b0;
      end else begin
         bus.running  <= state_n == RUN;
         bus.overflow <= state_n == DONE;
         bus.sec_tick <= tick && !bus.clear;
      end
   // prescaler advances only while running and keeps its phase otherwise
   always_ff @(posedge pixel_clk or negedge rst_n)
      if (!rst_n)             presc <= '0;
      else if (bus.clear)     presc <= '0;
      else if (state == RUN)  presc <= tick ? '0 : presc + 26'd1;
   // BCD time digits, frozen at 99:59
   always_ff @(posedge pixel_clk or negedge rst_n)
      if (!rst_n) {mt, mu, st, su} <= '0;
      else if (bus.clear) {mt, mu, st, su} <= '0;
      else if (tick && !at_max) begin
         su <= c_su ? 4'd0 : su + 4'd1;
         st <= c_su ? (c_st ? 4'd0 : st + 4'd1) : st;
         mu <= c_st ? (c_mu ? 4'd0 : mu + 4'd1) : mu;
         mt <= c_mu ? mt + 4'd1 : mt;
      end
   // lap register samples the pre-increment time whenever the timer has been started
   always_ff @(posedge pixel_clk or negedge rst_n)
      if (!rst_n) {l_mt, l_mu, l_st, l_su} <= '0;
      else if (bus.clear) {l_mt, l_mu, l_st, l_su} <= '0;
      else if (bus.lap && state != IDLE) {l_mt, l_mu, l_st, l_su} <= {mt, mu, st, su};
endmodule

// File: tb/tb_mmss_game_timer.sv
// tb_mmss_game_timer: randomized and directed checks against a seconds-count model
module tb_mmss_game_timer;
   localparam int TPS = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   mmss_game_timer_if bus();
   mmss_game_timer #(.TICKS_PER_SEC(TPS)) dut (.pixel_clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // model: time and lap as plain second counts, mode 0 idle 1 run 2 paused 3 done
   int m_secs = 0, m_lap = 0, m_phase = 0, m_mode = 0;
   bit m_tick = 0;
   logic m_t;
   assign m_t = m_mode == 1 && m_phase == TPS - 1;
   always @(posedge clk or negedge rst_n)
      if (!rst_n || bus.clear) begin
         m_secs <= 0; m_lap <= 0; m_phase <= 0; m_mode <= 0; m_tick <= 0;
      end else begin
         m_tick <= m_t;
         if (bus.lap && m_mode != 0) m_lap <= m_secs;
         if (m_mode == 1) m_phase <= m_t ? 0 : m_phase + 1;
         if (m_t && m_secs == 5999) m_mode <= 3;
         else begin
            if (m_t) m_secs <= m_secs + 1;
            if (bus.start_stop && m_mode != 3) m_mode <= (m_mode == 1) ? 2 : 1;
         end
      end
   function automatic logic [15:0] mmss(input int s);
      return {4'((s / 60) / 10), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction
   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic [34:0] exp_v, act_v;
      exp_v = {mmss(m_lap), mmss(m_secs), m_mode == 1, m_tick, m_mode == 3};
      act_v = {bus.sevseg_32bit_hex_val, bus.running, bus.sec_tick, bus.overflow};
      n_tests++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL cycle @%0t: hex/run/tick/ovf got %h/%b/%b/%b expected %h/%b/%b/%b", $time,
                  act_v[34:3], act_v[2], act_v[1], act_v[0], exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
      end
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic cyc(input bit ss, input bit cl, input bit lp);
      bus.start_stop = ss; bus.clear = cl; bus.lap = lp;
      @(posedge clk); #1;
      bus.start_stop = 0; bus.clear = 0; bus.lap = 0;
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0);
   endtask
   initial begin
      int ticks, first, last;
      bus.start_stop = 0; bus.clear = 0; bus.lap = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      check("reset_hex", bus.sevseg_32bit_hex_val, 32'h0);
      check("reset_flags", {29'd0, bus.running, bus.sec_tick, bus.overflow}, 32'h0);
      idle(5);
      check("idle_holds", {31'd0, bus.running}, 32'h0);
      cyc(1, 0, 0);
      check("start_running", {31'd0, bus.running}, 32'h1);
      ticks = 0; first = -1; last = -1;
      for (int i = 0; i < 40; i++) begin
         cyc(0, 0, 0);
         if (bus.sec_tick) begin
            if (first < 0) first = i;
            if (last >= 0) check("tick_spacing", i - last, 4);
            last = i;
            ticks++;
         end
      end
      check("tick_count", ticks, 10);
      check("first_tick", first, 3);
      check("basic_hex", bus.sevseg_32bit_hex_val, 32'h0000_0010);
      idle(196);
      check("at_59s", bus.sevseg_32bit_hex_val, 32'h0000_0059);
      idle(4);
      check("rollover_60s", bus.sevseg_32bit_hex_val, 32'h0000_0100);
      idle(5939 * 4);
      check("at_9959", bus.sevseg_32bit_hex_val, 32'h0000_9959);
      check("at_9959_running", {31'd0, bus.running}, 32'h1);
      idle(4);
      check("sat_hex", bus.sevseg_32bit_hex_val, 32'h0000_9959);
      check("sat_flags", {29'd0, bus.running, bus.sec_tick, bus.overflow}, 32'h3);
      cyc(1, 0, 0);
      idle(8);
      check("done_ignores_ss", {bus.sevseg_32bit_hex_val[15:0], 14'd0, bus.running, bus.overflow}, 32'h9959_0001);
      cyc(0, 1, 0);
      check("clear_from_done", {bus.sevseg_32bit_hex_val[30:0], bus.overflow}, 32'h0);
      cyc(1, 0, 0);
      idle(5);
      cyc(1, 0, 0);
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(0, 0, 0);
         if (bus.sec_tick) ticks++;
      end
      check("paused_no_ticks", ticks, 0);
      check("paused_hex", bus.sevseg_32bit_hex_val, 32'h0000_0001);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      check("resume_no_tick_yet", {31'd0, bus.sec_tick}, 32'h0);
      cyc(0, 0, 0);
      check("resume_tick", {31'd0, bus.sec_tick}, 32'h1);
      check("resume_hex", bus.sevseg_32bit_hex_val, 32'h0000_0002);
      idle(20);
      check("at_7s", bus.sevseg_32bit_hex_val, 32'h0000_0007);
      idle(3);
      cyc(0, 0, 1);
      check("lap_on_tick", bus.sevseg_32bit_hex_val, 32'h0007_0008);
      idle(746 * 4);
      check("at_1234", bus.sevseg_32bit_hex_val, 32'h0007_1234);
      cyc(1, 1, 1);
      check("clear_wins_hex", bus.sevseg_32bit_hex_val, 32'h0);
      check("clear_wins_run", {31'd0, bus.running}, 32'h0);
      idle(10);
      check("clear_stays_idle", {31'd0, bus.running}, 32'h0);
      cyc(1, 0, 0);
      idle(6);
      check("pre_reset_hex", bus.sevseg_32bit_hex_val, 32'h0000_0001);
      rst_n = 0;
      #1;
      check("async_reset_hex", bus.sevseg_32bit_hex_val, 32'h0);
      check("async_reset_flags", {29'd0, bus.running, bus.sec_tick, bus.overflow}, 32'h0);
      @(posedge clk); #1 rst_n = 1;
      idle(4);
      check("post_reset_idle", {bus.sevseg_32bit_hex_val[30:0], bus.running}, 32'h0);
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(15) == 0, $urandom_range(499) == 0, $urandom_range(9) == 0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mmss_game_timer.md
MMSS_GAME_TIMER -- requirements
Module: mmss_game_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 25_200_000, pixel_clk cycles per counted second; legal range 2..2^26-1.
REQ-002 pixel_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start_stop  input  1  single-cycle pulse (debounced button-down); toggles run/pause.
REQ-005 clear  input  1  single-cycle pulse; returns the timer to zero/IDLE.
REQ-006 lap  input  1  single-cycle pulse; captures the current time into the lap register.
REQ-007 sevseg_32bit_hex_val  output  32  {lap_mt, lap_mu, lap_st, lap_su, mt, mu, st, su}, one BCD digit per nibble; drives the 7-segment controller.
REQ-008 running  output  1  high while in state RUN.
REQ-009 sec_tick  output  1  one-cycle pulse on every counted second.
REQ-010 overflow  output  1  high while in state DONE.

Function
REQ-011 States SHALL be IDLE, RUN, PAUSED and DONE.
REQ-012 The prescaler SHALL count 0..TICKS_PER_SEC-1 only in RUN, and SHALL hold its value in every other state.
REQ-013 At prescaler = TICKS_PER_SEC-1 in RUN, the prescaler SHALL wrap to 0 and sec_tick SHALL assert for exactly that cycle+1 (registered), coincident with the BCD update.
REQ-014 BCD increment SHALL follow these rollover rules:
- su 0-9 carries into st;
- st 0-5 carries into mu;
- mu 0-9 carries into mt;
- mt 0-9.
REQ-015 A tick at 99:59 SHALL leave the time at 99:59 and enter DONE; sec_tick still pulses for that tick.
REQ-016 Transitions on start_stop SHALL be:
- IDLE->RUN;
- RUN->PAUSED;
- PAUSED->RUN;
- ignored in DONE.
Each transition takes effect on the next edge.
REQ-017 clear SHALL move any state to IDLE and zero the time digits, lap digits, prescaler and overflow.
REQ-018 clear SHALL win over a same-cycle start_stop, lap or tick.
REQ-019 lap SHALL capture the time in RUN, PAUSED and DONE, and SHALL be ignored in IDLE.
REQ-020 A lap coincident with a tick SHALL capture the pre-increment time.
REQ-021 A start_stop coincident with a tick in RUN SHALL both apply the increment and move to PAUSED.
REQ-022 Resuming from PAUSED SHALL continue from the held prescaler value, so no partial second is lost or added.
REQ-023 All outputs SHALL be registered; sevseg_32bit_hex_val SHALL reflect new digits one cycle after the causing edge at most.
REQ-024 Every nibble of sevseg_32bit_hex_val SHALL always be a valid BCD value (0-9, tens-of-seconds 0-5).
REQ-025 Input pulses longer than one cycle SHALL be treated as one event per high cycle; edge detection is not required, because debounced down-pulses are the contract.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously force the following:
- state IDLE;
- prescaler, all eight digits and sevseg_32bit_hex_val = 32'h0000_0000;
- running = 0, sec_tick = 0, overflow = 0.
REQ-027 Reset asserted mid-count SHALL discard all time and lap state.
REQ-028 After rst_n deasserts, the block SHALL stay in IDLE until a start_stop pulse.

Verification (TICKS_PER_SEC = 4 unless stated)
REQ-029 Basic count:
- Stimulus: reset, start_stop, run 40 cycles.
- Response: running = 1, 10 sec_tick pulses spaced 4 cycles, hex = 32'h0000_0010.
REQ-030 Rollover and saturation:
- Stimulus: run to 59 s, then 1 more tick; separately, run to 99:59, then 1 tick.
- Response: first case hex = 32'h0000_0100; second case hex = 32'h0000_9959, overflow = 1, running = 0, further start_stop ignored.
REQ-031 Pause preserves phase:
- Stimulus: start; pause after 6 cycles; idle 100 cycles; resume.
- Response: no ticks while paused; next tick 2 cycles after resume.
REQ-032 Lap:
- Stimulus: lap at 00:07, coincident with the tick to 00:08.
- Response: hex = 32'h0007_0008.
REQ-033 Clear and reset:
- Stimulus: clear asserted together with start_stop and lap while at 12:34 in RUN; separately, rst_n pulsed low mid-second.
- Response: clear gives hex = 0, IDLE, running = 0; the rst_n pulse gives all outputs 0 immediately, without waiting for a clock edge.
